pixel_block_writer: RTL and testbench
=====================================

# pixel_block_writer

Downstream consumer of the 2x2 pixel-block fetch stage. It accepts one 2x2 block of 8-bit pixels per handshake, reduces the block to a single averaged pixel through a two-stage pipeline, and writes the result into the 160x120 output frame buffer at a sequential address. It counts written pixels, signals end-of-frame, and then stops accepting data until the next start.

## Interface
Parameters:
- OUT_W, 160, output frame width in pixels
- OUT_H, 120, output frame height in pixels
- ADDR_W, 15, width of write address and pixel counter; must satisfy 2^ADDR_W >= OUT_W*OUT_H

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a frame; honoured only in IDLE or DONE
- in_valid  in  1  p0..p3 hold a valid block
- in_ready  out  1  block accepted on an edge where in_valid && in_ready
- p0  in  8  top-left pixel
- p1  in  8  top-right pixel
- p2  in  8  bottom-left pixel
- p3  in  8  bottom-right pixel
- wr_en  out  1  frame-buffer write strobe, one cycle per pixel
- wr_addr  out  ADDR_W  frame-buffer write address
- wr_data  out  8  averaged pixel
- busy  out  1  high in RUN or while the pipeline holds data
- frame_done  out  1  one-cycle pulse on the final write of a frame
- pix_count  out  ADDR_W  number of blocks accepted in the current frame

## Operation
- States:
  - IDLE: after reset.
  - RUN: start in IDLE or DONE -> RUN; pix_count cleared to 0 on that edge.
  - DONE: entered on the edge that accepts block OUT_W*OUT_H-1.
  - start in RUN is ignored.
- in_ready = (state == RUN), combinational. It is low in IDLE and DONE, and low during the cycle after the last accept.
- Stage 1, on accept:
  - sum_r <= p0+p1+p2+p3, 10 bits; no overflow, maximum 1020.
  - addr_r <= pix_count; v1 <= 1; pix_count <= pix_count+1.
  - On the last accept: last1 <= 1.
  - With no accept: v1 <= 0.
- Stage 2, every edge:
  - wr_en <= v1.
  - If v1: wr_addr <= addr_r and wr_data <= avg(sum_r).
  - frame_done <= v1 && last1.
- Averaging arithmetic is set by the Configuration macro. The result is always 8 bits and never saturates.
- Addresses are strictly sequential: 0 .. OUT_W*OUT_H-1. Gaps in in_valid do not skip or repeat addresses.
- pix_count holds at OUT_W*OUT_H in DONE until the next start clears it.
- busy = (state == RUN) || v1 || wr_en.

## Timing
- Reset values: in_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, frame_done 0, pix_count 0, state IDLE. Pipeline valids are cleared.
- Latency: block accepted at edge k -> wr_en high for the cycle following edge k+1. Fixed 2 cycles.
- Throughput: 1 block/cycle with in_valid held high.
- No backpressure from the frame buffer; a write always completes in its single cycle.
- frame_done is high in the same cycle as the final wr_en (wr_addr = OUT_W*OUT_H-1).
- start arriving on the frame_done cycle (state DONE) restarts immediately. The final write is unaffected, since it is already in the pipeline.
- rst mid-frame:
  - All state is cleared asynchronously.
  - In-flight pipeline data is discarded with no write.
  - The next frame requires start.

## Configuration
- PIXEL_BLOCK_WRITER_ROUND_EN defined: avg = (sum_r + 2) >> 2, round-half-up. The maximum intermediate value is 1022, which fits in 10 bits.
- Undefined, the default: avg = sum_r >> 2, truncation.
- Interface and timing are identical in both builds.

## Test plan
- Reset check: assert rst, then release.
  - All outputs hold their reset values.
  - in_ready stays 0 with no start.
  - in_valid pulses cause no writes.
- Single block: start, then one block 10,20,30,42 (sum 102).
  - wr_en is high 2 cycles after accept, wr_addr = 0.
  - wr_data = 25 without the macro, 26 with it.
- Full frame: 19200 back-to-back blocks, all 255.
  - wr_addr runs 0..19199 contiguously; wr_data = 255 in both builds.
  - frame_done pulses once, with wr_addr = 19199.
  - in_ready drops after the last accept; pix_count = 19200.
- Gapped input: toggle in_valid in a random pattern for 100 blocks.
  - Exactly 100 writes at addresses 0..99.
  - Each wr_data matches the reference average of its block.
- Mid-frame events:
  - start pulsed at block 50: ignored, and addressing continues at 51.
  - rst at block 500: no further wr_en, pix_count = 0.
  - A following start restarts at wr_addr 0.

Source files
------------

// File: rtl/pixel_block_writer.sv
// pixel_block_writer
// Accepts one 2x2 block of 8-bit pixels per handshake, averages the block
// through a two-stage pipeline and writes the result to a sequential
// frame-buffer address. Counts accepted blocks, pulses frame_done on the
// final write of a frame, then stops accepting until the next start.
//
// Build option: define PIXEL_BLOCK_WRITER_ROUND_EN for round-half-up
// averaging; otherwise the average truncates.

module pixel_block_writer #(
    parameter int OUT_W  = 160,
    parameter int OUT_H  = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        p0,
    input  logic [7:0]        p1,
    input  logic [7:0]        p2,
    input  logic [7:0]        p3,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] pix_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int                PIX_TOTAL = OUT_W * OUT_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_TOTAL - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);

    // Reduce a 10-bit block sum to one 8-bit pixel; never saturates because
    // the biased maximum (1022) still fits in 10 bits.
    function automatic logic [7:0] block_avg(input logic [9:0] sum);
`ifdef PIXEL_BLOCK_WRITER_ROUND_EN
        logic [9:0] biased;
        biased = sum + 10'd2;
        return biased[9:2];
`else
        return sum[9:2];
`endif
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] pix_count_r;
    logic [9:0]        sum_r;
    logic [ADDR_W-1:0] addr_r;
    logic              v1_r;
    logic              last1_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [7:0]        wr_data_r;
    logic              frame_done_r;

    logic              in_ready_s;
    logic              accept_s;
    logic              last_accept_s;
    logic              start_ok_s;
    logic [9:0]        sum_s;

    // Handshake decode, start qualification, block sum and next state.
    always_comb begin
        in_ready_s    = 1'b0;
        accept_s      = 1'b0;
        last_accept_s = 1'b0;
        start_ok_s    = 1'b0;
        state_next_s  = state_r;
        sum_s         = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};

        if (state_r == ST_RUN) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end

        accept_s = in_valid && in_ready_s;

        if (accept_s && (pix_count_r == LAST_ADDR)) begin
            last_accept_s = 1'b1;
        end else begin
            last_accept_s = 1'b0;
        end

        if (start && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
            start_ok_s = 1'b1;
        end else begin
            start_ok_s = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_accept_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start_ok_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Accepted-block counter: cleared by an honoured start, holds at the
    // frame size once the frame is complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_count_r <= ADDR_ZERO;
        end else if (start_ok_s) begin
            pix_count_r <= ADDR_ZERO;
        end else if (accept_s) begin
            pix_count_r <= pix_count_r + ADDR_ONE;
        end
    end

    // Stage 1: capture block sum and its address on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r   <= 10'd0;
            addr_r  <= ADDR_ZERO;
            v1_r    <= 1'b0;
            last1_r <= 1'b0;
        end else if (accept_s) begin
            sum_r   <= sum_s;
            addr_r  <= pix_count_r;
            v1_r    <= 1'b1;
            last1_r <= last_accept_s;
        end else begin
            v1_r    <= 1'b0;
            last1_r <= 1'b0;
        end
    end

    // Stage 2: averaged write to the frame buffer and end-of-frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_r      <= 1'b0;
            wr_addr_r    <= ADDR_ZERO;
            wr_data_r    <= 8'd0;
            frame_done_r <= 1'b0;
        end else begin
            wr_en_r      <= v1_r;
            frame_done_r <= v1_r && last1_r;
            if (v1_r) begin
                wr_addr_r <= addr_r;
                wr_data_r <= block_avg(sum_r);
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign busy       = in_ready_s || v1_r || wr_en_r;
    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign frame_done = frame_done_r;
    assign pix_count  = pix_count_r;

endmodule

// File: tb/tb_pixel_block_writer.sv
// Self-checking bench for pixel_block_writer: directed vector table plus
// hand-written sequences for full-frame, gapped input, restart and reset.

module tb_pixel_block_writer;

    localparam int OUT_W  = 160;
    localparam int OUT_H  = 120;
    localparam int ADDR_W = 15;
    localparam int TOTAL  = OUT_W * OUT_H;
    localparam int LAST   = TOTAL - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        p0 = 8'd0;
    logic [7:0]        p1 = 8'd0;
    logic [7:0]        p2 = 8'd0;
    logic [7:0]        p3 = 8'd0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              frame_done;
    logic [ADDR_W-1:0] pix_count;

    pixel_block_writer #(.OUT_W(OUT_W), .OUT_H(OUT_H), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .p0(p0), .p1(p1), .p2(p2), .p3(p3),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .frame_done(frame_done), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a, b, c, d;
        logic [7:0] exp_trunc, exp_round;
    } vec_t;

    typedef struct {
        int addr;
        int data;
        int acc_edge;
    } exp_t;

    int   n_chk = 0;
    int   n_pass = 0;
    int   n_wr = 0;
    int   n_fd = 0;
    int   exp_addr = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic int ref_avg(input int s);
`ifdef PIXEL_BLOCK_WRITER_ROUND_EN
        return (s + 2) / 4;
`else
        return s / 4;
`endif
    endfunction

    function automatic int sel_exp(input vec_t v);
`ifdef PIXEL_BLOCK_WRITER_ROUND_EN
        return int'(v.exp_round);
`else
        return int'(v.exp_trunc);
`endif
    endfunction

    // Scoreboard step, run at every falling edge.
    task automatic mon_step();
        exp_t e;
        if (wr_en === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check("unexpected_wr_en", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", int'(wr_addr), e.addr);
                check("wr_data", int'(wr_data), e.data);
                check("latency", cyc, e.acc_edge + 1);
                check("frame_done_on_write", int'(frame_done), (e.addr == LAST) ? 1 : 0);
                if (frame_done === 1'b1) n_fd++;
            end
        end else if (frame_done !== 1'b0) begin
            check("frame_done_without_write", 1, 0);
        end
    endtask

    // Present a block at a falling edge and hold it until accepted.
    task automatic send(input logic [7:0] a, b, c, d, input int exp, input logic st);
        int n;
        @(negedge clk);
        p0 = a; p1 = b; p2 = c; p3 = d;
        in_valid = 1'b1;
        start = st;
        #1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            check("accept_timeout", 0, 1);
        end else begin
            exp_q.push_back('{exp_addr, exp, cyc + 1});
            exp_addr++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            start = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_addr = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   first_edge;
        int   last_edge;
        int   base;
        logic [7:0] ra, rb, rc, rd;

        tbl[0] = '{8'd10,  8'd20,  8'd30,  8'd42,  8'd25,  8'd26};
        tbl[1] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0};
        tbl[2] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        tbl[3] = '{8'd1,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0};
        tbl[4] = '{8'd1,   8'd1,   8'd0,   8'd0,   8'd0,   8'd1};
        tbl[5] = '{8'd255, 8'd255, 8'd255, 8'd254, 8'd254, 8'd255};
        tbl[6] = '{8'd100, 8'd101, 8'd102, 8'd103, 8'd101, 8'd102};
        tbl[7] = '{8'd3,   8'd3,   8'd3,   8'd2,   8'd2,   8'd3};

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        // Reset values.
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_in_ready",   int'(in_ready),   0);
        check("rst_wr_en",      int'(wr_en),      0);
        check("rst_wr_addr",    int'(wr_addr),    0);
        check("rst_wr_data",    int'(wr_data),    0);
        check("rst_busy",       int'(busy),       0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_pix_count",  int'(pix_count),  0);
        @(negedge clk);
        rst = 1'b0;

        // in_valid without start is never accepted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            p0 = 8'd7; p1 = 8'd7; p2 = 8'd7; p3 = 8'd7;
            #1;
            check("idle_in_ready", int'(in_ready), 0);
        end
        idle(3);
        check("idle_pix_count", int'(pix_count), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_writes", n_wr, 0);

        // Frame 1: directed table, then fill with 255 blocks.
        pulse_start();
        #1;
        check("start_in_ready", int'(in_ready), 1);
        check("start_pix_count", int'(pix_count), 0);
        check("start_busy", int'(busy), 1);

        send(tbl[0].a, tbl[0].b, tbl[0].c, tbl[0].d, sel_exp(tbl[0]), 1'b0);
        idle(4);
        check("single_pix_count", int'(pix_count), 1);
        check("single_written", n_wr, 1);

        for (int i = 1; i < 8; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, sel_exp(tbl[i]), 1'b0);
            idle(i % 2);
        end

        first_edge = 0;
        last_edge = 0;
        for (int i = 8; i < TOTAL; i++) begin
            send(8'd255, 8'd255, 8'd255, 8'd255, 255, 1'b0);
            if (i == 8) first_edge = exp_q[$].acc_edge;
            if (i == LAST) last_edge = exp_q[$].acc_edge;
        end
        check("throughput_edges", last_edge - first_edge, TOTAL - 9);

        // Cycle after the last accept: DONE, counter at frame size.
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("done_in_ready", int'(in_ready), 0);
        check("done_pix_count", int'(pix_count), TOTAL);
        check("done_busy", int'(busy), 1);

        // frame_done cycle: restart immediately.
        @(negedge clk);
        start = 1'b1;
        #1;
        check("frame_done_cycle", int'(frame_done), 1);
        check("frame_done_addr", int'(wr_addr), LAST);
        @(negedge clk);
        start = 1'b0;
        exp_addr = 0;
        #1;
        check("restart_in_ready", int'(in_ready), 1);
        check("restart_pix_count", int'(pix_count), 0);
        check("frame_done_pulses", n_fd, 1);
        check("frame1_drained", exp_q.size(), 0);

        // Frame 2: 100 gapped random blocks, start at block 50 is ignored.
        base = n_wr;
        for (int i = 0; i < 100; i++) begin
            idle($urandom_range(0, 2));
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 8'($urandom_range(0, 255));
            rd = 8'($urandom_range(0, 255));
            send(ra, rb, rc, rd, ref_avg(int'(ra) + int'(rb) + int'(rc) + int'(rd)), (i == 50) ? 1'b1 : 1'b0);
        end
        idle(4);
        check("gapped_writes", n_wr - base, 100);
        check("gapped_pix_count", int'(pix_count), 100);
        check("gapped_drained", exp_q.size(), 0);

        for (int i = 100; i < 500; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 8'($urandom_range(0, 255));
            rd = 8'($urandom_range(0, 255));
            send(ra, rb, rc, rd, ref_avg(int'(ra) + int'(rb) + int'(rc) + int'(rd)), 1'b0);
        end

        // Reset with data in flight: discarded, no further writes.
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        exp_q.delete();
        base = n_wr;
        #1;
        check("midrst_wr_en", int'(wr_en), 0);
        check("midrst_pix_count", int'(pix_count), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_busy", int'(busy), 0);
        idle(2);
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        check("post_rst_writes", n_wr, base);
        check("post_rst_in_ready", int'(in_ready), 0);

        // Frame 3: restart at address 0.
        pulse_start();
        send(tbl[0].a, tbl[0].b, tbl[0].c, tbl[0].d, sel_exp(tbl[0]), 1'b0);
        idle(4);
        check("frame3_writes", n_wr - base, 1);
        check("frame3_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
